i2s_tx_param: RTL and testbench
===============================

// Module: i2s_tx_param
// PURPOSE
//  Parametrised I2S / left-justified audio transmitter for the ADAU codec path.
//  Single clock domain (ac_mclk). Stereo samples arrive over a valid/ready handshake
//  into an internal synchronous FIFO, then are serialised as bclk/lrclk/sdata.
//  Adds configurable widths, divider, framing mode, underrun handling and clean
//  enable/disable at frame boundaries.
// PARAMETERS
//  DATA_W     24  sample width per channel
//  SLOT_W     32  bclk periods per channel slot; MODE=0 needs SLOT_W>=DATA_W+1, MODE=1 needs SLOT_W>=DATA_W
//  MCLK_DIV   2   ac_mclk cycles per bclk period; even, >=2
//  FIFO_DEPTH 4   stereo entries held; power of two, >=2
//  MODE       0   0 = I2S (MSB one bclk after lrclk edge), 1 = left-justified
// PORTS
//  ac_mclk    in   1                 sole clock; all logic on posedge
//  reset      in   1                 asynchronous, active-high
//  enable     in   1                 run serialiser; sampled at frame boundary only
//  s_valid    in   1                 sample pair valid
//  s_ready    out  1                 = !fifo_full
//  s_data_l   in   DATA_W            left sample, two's complement
//  s_data_r   in   DATA_W            right sample
//  bclk       out  1                 bit clock (registered)
//  lrclk      out  1                 0 = left slot, 1 = right slot (registered)
//  sdata      out  1                 serial data, MSB first (registered)
//  underrun   out  1                 1-cycle pulse: frame started with FIFO empty
//  fifo_level out  $clog2(FIFO_DEPTH)+1  entries currently stored
// BEHAVIOUR
//  Reset (async): bclk=0, lrclk=1, sdata=0, underrun=0, fifo_level=0, s_ready=1,
//   FIFO pointers/shift regs cleared, serialiser IDLE. Reset mid-frame aborts the frame
//   and flushes the FIFO.
//  Push: s_valid&&s_ready at posedge writes {l,r}; no push when full, even if pop in same cycle.
//  FSM: IDLE -> RUN when enable=1 (checked every cycle in IDLE); RUN -> IDLE at a frame
//   boundary when enable=0. IDLE holds bclk=0, lrclk=1, sdata=0.
//  Divider: div_cnt 0..MCLK_DIV-1; bclk rises when div_cnt=MCLK_DIV/2, falls at div_cnt wrap to 0.
//   sdata and lrclk change only on the cycle bclk falls (codec samples on rising edge).
//  Bit position k = 0..SLOT_W-1 within slot, advanced at each falling edge.
//   MODE=0: k=0 -> 0; 1<=k<=DATA_W -> d[DATA_W-k]; else 0.
//   MODE=1: k<DATA_W -> d[DATA_W-1-k]; else 0.
//  Frame boundary = falling edge starting left slot k=0 (also first edge after IDLE->RUN):
//   lrclk<=0; pop FIFO in that cycle into l/r shift regs. If empty: load zeros (mute),
//   underrun=1 for that cycle, no pop. Right slot starts at SLOT_W bclks later: lrclk<=1.
//  Latency: entry written >=1 cycle before the frame-boundary cycle is sent in that frame;
//   push and pop in the same cycle on an empty FIFO -> underrun (no bypass).
//  Frame = 2*SLOT_W*MCLK_DIV ac_mclk cycles; fifo_level = writes-pops, saturates at FIFO_DEPTH.
// STRUCTURE
//  Package i2s_pkg: MODE_I2S/MODE_LJ localparams, FSM state encoding (IDLE,RUN), width helper.
//  Sub-module i2s_sync_fifo (single-clock, width 2*DATA_W, depth FIFO_DEPTH, full/empty/level).
//  Top: FSM, divider, bit/slot counters, shift regs, output regs.
// TESTING
//  1 Defaults, push L=24'hA5A5A5 R=24'h5A5A5A, enable=1 -> left MSB on 2nd bclk after lrclk fall,
//    24 bits then 7 zeros; right identical pattern; frame = 128 ac_mclk cycles.
//  2 MODE=1, DATA_W=16, SLOT_W=16, L=16'h8001 -> sdata=1 on first bclk after lrclk fall, 1 at bit 15.
//  3 Underrun: enable with empty FIFO -> underrun pulses once per frame, sdata=0 throughout,
//    level stays 0; push one pair -> sent next frame, underrun absent that frame.
//  4 Full: push 4 pairs with enable=0 -> s_ready=0, level=4; 5th valid ignored; enable -> FIFO order kept.
//  5 Drop enable mid-left-slot -> current frame completes (right slot sent), then bclk=0, lrclk=1.
//  6 Assert reset mid-right-slot -> outputs at reset values same cycle (async), level=0, restart clean.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared constants, FSM encoding and width helper for the I2S transmitter.
package i2s_pkg;

    localparam int MODE_I2S = 0;  // MSB one bclk after the lrclk edge
    localparam int MODE_LJ  = 1;  // MSB coincident with the lrclk edge

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/i2s_sync_fifo.sv
// Single-clock FIFO holding stereo pairs; pointers carry one extra wrap bit
// so full/empty/level fall out of a plain subtraction.
module i2s_sync_fifo
    import i2s_pkg::*;
#(
    parameter int W     = 48,
    parameter int DEPTH = 4   // power of two, >= 2
) (
    input  logic                     ac_mclk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = cnt_w(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         do_wr, do_rd;

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    // A write is refused while full even if a read frees a slot this cycle.
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; reset flushes any stored entries.
    always_ff @(posedge ac_mclk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since level gates every read.
    always_ff @(posedge ac_mclk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/i2s_tx_param.sv
// I2S / left-justified serialiser: FIFO-buffered stereo pairs shifted out as
// bclk/lrclk/sdata, with frame-aligned enable and underrun muting.
module i2s_tx_param
    import i2s_pkg::*;
#(
    parameter int DATA_W     = 24,
    parameter int SLOT_W     = 32,  // I2S needs DATA_W+1, LJ needs DATA_W
    parameter int MCLK_DIV   = 2,   // even, >= 2
    parameter int FIFO_DEPTH = 4,
    parameter int MODE       = 0
) (
    input  logic                          ac_mclk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_W-1:0]             s_data_l,
    input  logic [DATA_W-1:0]             s_data_r,
    output logic                          bclk,
    output logic                          lrclk,
    output logic                          sdata,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int DIV_W = cnt_w(MCLK_DIV);
    localparam int KW    = cnt_w(SLOT_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(MCLK_DIV / 2 - 1);
    localparam logic [KW-1:0]    K_LAST   = KW'(SLOT_W - 1);

    typedef struct packed {
        logic [DATA_W-1:0] l;
        logic [DATA_W-1:0] r;
    } pair_t;

    pair_t             wr_pair, rd_pair;
    logic              fifo_full, fifo_empty, pop;
    state_t            state;
    logic [DIV_W-1:0]  div_cnt;
    logic [KW-1:0]     bit_k;
    logic              slot;       // 0 = left, 1 = right
    logic [DATA_W-1:0] l_reg, r_reg;
    logic              frame_end, frame_start;

    // Bit driven at slot position k, MSB first, zero padded.
    function automatic logic bit_sel(input logic [DATA_W-1:0] d, input logic [KW-1:0] k);
        int                ki;
        logic [DATA_W-1:0] t;
        ki      = int'(k);
        t       = '0;
        bit_sel = 1'b0;
        if (MODE == MODE_I2S) begin
            if (ki >= 1 && ki <= DATA_W) begin
                t       = d >> (DATA_W - ki);
                bit_sel = t[0];
            end
        end else if (ki < DATA_W) begin
            t       = d >> (DATA_W - 1 - ki);
            bit_sel = t[0];
        end
    endfunction

    assign wr_pair     = {s_data_l, s_data_r};
    assign s_ready     = !fifo_full;
    assign frame_end   = (state == RUN) && (div_cnt == DIV_LAST) && (bit_k == K_LAST) && slot;
    // Enable only matters in IDLE or on the falling edge that ends a frame.
    assign frame_start = enable && ((state == IDLE) || frame_end);
    assign pop         = frame_start && !fifo_empty;

    i2s_sync_fifo #(
        .W     (2 * DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .ac_mclk (ac_mclk),
        .reset   (reset),
        .wr_en   (s_valid && s_ready),
        .wr_data (wr_pair),
        .rd_en   (pop),
        .rd_data (rd_pair),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Serialiser FSM: divider, bit/slot counters, frame loads and output regs.
    always_ff @(posedge ac_mclk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_k    <= '0;
            slot     <= 1'b0;
            l_reg    <= '0;
            r_reg    <= '0;
            bclk     <= 1'b0;
            lrclk    <= 1'b1;
            sdata    <= 1'b0;
            underrun <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (frame_start) begin
                // Falling edge that opens the left slot; mute if nothing queued.
                state   <= RUN;
                div_cnt <= '0;
                bit_k   <= '0;
                slot    <= 1'b0;
                bclk    <= 1'b0;
                lrclk   <= 1'b0;
                if (fifo_empty) begin
                    l_reg    <= '0;
                    r_reg    <= '0;
                    sdata    <= 1'b0;
                    underrun <= 1'b1;
                end else begin
                    l_reg <= rd_pair.l;
                    r_reg <= rd_pair.r;
                    sdata <= bit_sel(rd_pair.l, '0);
                end
            end else if (state == IDLE) begin
                bclk    <= 1'b0;
                lrclk   <= 1'b1;
                sdata   <= 1'b0;
                div_cnt <= '0;
            end else if (div_cnt == DIV_LAST) begin
                // Falling bclk edge: data and lrclk move here only.
                div_cnt <= '0;
                bclk    <= 1'b0;
                if (bit_k == K_LAST) begin
                    bit_k <= '0;
                    if (slot) begin
                        state <= IDLE;
                        lrclk <= 1'b1;
                        sdata <= 1'b0;
                    end else begin
                        slot  <= 1'b1;
                        lrclk <= 1'b1;
                        sdata <= bit_sel(r_reg, '0);
                    end
                end else begin
                    bit_k <= bit_k + 1'b1;
                    sdata <= bit_sel(slot ? r_reg : l_reg, bit_k + 1'b1);
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
                if (div_cnt == DIV_RISE) bclk <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_param.sv
// Bench for i2s_tx_param: a default I2S instance and a 16-bit left-justified
// instance, with a codec-side monitor that rebuilds slot words from rising bclk.
module tb_i2s_tx_param;

    logic ac_mclk = 1'b0;
    logic reset   = 1'b1;
    always #5 ac_mclk = ~ac_mclk;

    // default instance
    logic        enable = 0, s_valid = 0, s_ready, bclk, lrclk, sdata, underrun;
    logic [23:0] s_data_l = '0, s_data_r = '0;
    logic [2:0]  fifo_level;
    // left-justified instance
    logic        lj_enable = 0, lj_valid = 0, lj_ready, lj_bclk, lj_lrclk, lj_sdata, lj_underrun;
    logic [15:0] lj_l = '0, lj_r = '0;
    logic [2:0]  lj_level;

    i2s_tx_param u_dut (
        .ac_mclk(ac_mclk), .reset(reset), .enable(enable), .s_valid(s_valid), .s_ready(s_ready),
        .s_data_l(s_data_l), .s_data_r(s_data_r), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
        .underrun(underrun), .fifo_level(fifo_level)
    );

    i2s_tx_param #(.DATA_W(16), .SLOT_W(16), .MCLK_DIV(2), .FIFO_DEPTH(4), .MODE(1)) u_lj (
        .ac_mclk(ac_mclk), .reset(reset), .enable(lj_enable), .s_valid(lj_valid), .s_ready(lj_ready),
        .s_data_l(lj_l), .s_data_r(lj_r), .bclk(lj_bclk), .lrclk(lj_lrclk), .sdata(lj_sdata),
        .underrun(lj_underrun), .fifo_level(lj_level)
    );

    int n_chk = 0, n_fail = 0, cyc = 0;
    always @(posedge ac_mclk) cyc++;

    // Codec view of the default instance: frames, per-frame underrun flag, frame start times.
    logic [31:0] mw_l, mw_r;
    logic        mprev_b = 0, mprev_lr = 1, cprev_lr = 1;
    int          mn = 0, stray = 0;
    logic [63:0] frm_q[$];
    bit          ur_q[$];
    int          fall_q[$];
    always @(negedge ac_mclk) begin
        if (reset) begin
            mn = 0; mprev_b = 0; mprev_lr = 1; cprev_lr = 1;
        end else begin
            if (!lrclk && cprev_lr) begin
                ur_q.push_back(underrun);
                fall_q.push_back(cyc);
            end else if (underrun) stray++;
            cprev_lr = lrclk;
            if (bclk && !mprev_b) begin
                if (!lrclk && mprev_lr) mn = 0;
                if (!lrclk) mw_l = {mw_l[30:0], sdata}; else mw_r = {mw_r[30:0], sdata};
                mn++;
                if (mn == 64) begin frm_q.push_back({mw_l, mw_r}); mn = 0; end
                mprev_lr = lrclk;
            end
            mprev_b = bclk;
        end
    end

    // Codec view of the left-justified instance.
    logic [15:0] lw_l, lw_r;
    logic        lprev_b = 0, lprev_lr = 1;
    int          ln = 0;
    logic [31:0] lq[$];
    always @(negedge ac_mclk) begin
        if (reset) begin
            ln = 0; lprev_b = 0; lprev_lr = 1;
        end else begin
            if (lj_bclk && !lprev_b) begin
                if (!lj_lrclk && lprev_lr) ln = 0;
                if (!lj_lrclk) lw_l = {lw_l[14:0], lj_sdata}; else lw_r = {lw_r[14:0], lj_sdata};
                ln++;
                if (ln == 32) begin lq.push_back({lw_l, lw_r}); ln = 0; end
                lprev_lr = lj_lrclk;
            end
            lprev_b = lj_bclk;
        end
    end

    // Expected I2S slot word: one leading zero, the sample, zero padding.
    function automatic logic [31:0] exp_i2s(input logic [23:0] d);
        return {1'b0, d, 7'b0};
    endfunction

    logic [47:0] exp_q[$];  // pairs in FIFO order: {l, r}

    task automatic tick(input int n);
        repeat (n) @(posedge ac_mclk);
        #1;
    endtask

    task automatic clear_mon();
        frm_q.delete(); ur_q.delete(); fall_q.delete(); lq.delete(); exp_q.delete(); stray = 0;
    endtask

    task automatic push(input logic [23:0] l, input logic [23:0] r);
        s_data_l = l; s_data_r = r; s_valid = 1;
        tick(1);
        s_valid = 0;
        exp_q.push_back({l, r});
    endtask

    task automatic push_rand();
        push(24'($urandom()), 24'($urandom()));
    endtask

    task automatic wait_frames(input int n, output bit ok);
        for (int i = 0; i < n * 128 + 300 && frm_q.size() < n; i++) tick(1);
        ok = (frm_q.size() >= n);
    endtask

    task automatic stop_and_idle();
        enable = 0;
        tick(300);
    endtask

    task automatic test_reset();
        tick(3);
        n_chk++; if (bclk !== 1'b0)  begin n_fail++; $display("FAIL reset_bclk: got %b want 0", bclk); end
        n_chk++; if (lrclk !== 1'b1) begin n_fail++; $display("FAIL reset_lrclk: got %b want 1", lrclk); end
        n_chk++; if (sdata !== 1'b0) begin n_fail++; $display("FAIL reset_sdata: got %b want 0", sdata); end
        n_chk++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b want 0", underrun); end
        n_chk++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        n_chk++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", s_ready); end
        n_chk++; if (lj_lrclk !== 1'b1) begin n_fail++; $display("FAIL reset_lj_lrclk: got %b want 1", lj_lrclk); end
        reset = 0;
        tick(2);
        n_chk++; if (bclk !== 1'b0 || lrclk !== 1'b1) begin n_fail++; $display("FAIL idle_after_reset: got bclk=%b lrclk=%b want 0/1", bclk, lrclk); end
    endtask

    task automatic test_basic();
        bit ok;
        logic [47:0] e;
        clear_mon();
        push(24'hA5A5A5, 24'h5A5A5A);
        push_rand();
        push_rand();
        n_chk++; if (fifo_level !== 3'd3) begin n_fail++; $display("FAIL basic_level: got %0d want 3", fifo_level); end
        enable = 1;
        wait_frames(3, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL basic_timeout: got %0d frames want 3", frm_q.size()); end
        if (ok) begin
            for (int i = 0; i < 3; i++) begin
                e = exp_q.pop_front();
                n_chk++;
                if (frm_q[i] !== {exp_i2s(e[47:24]), exp_i2s(e[23:0])}) begin
                    n_fail++; $display("FAIL basic_frame%0d: got %h want %h", i, frm_q[i], {exp_i2s(e[47:24]), exp_i2s(e[23:0])});
                end
                n_chk++; if (ur_q[i] !== 1'b0) begin n_fail++; $display("FAIL basic_ur%0d: got %b want 0", i, ur_q[i]); end
            end
            n_chk++; if (fall_q[1] - fall_q[0] != 128) begin n_fail++; $display("FAIL basic_period0: got %0d want 128", fall_q[1] - fall_q[0]); end
            n_chk++; if (fall_q[2] - fall_q[1] != 128) begin n_fail++; $display("FAIL basic_period1: got %0d want 128", fall_q[2] - fall_q[1]); end
        end
        n_chk++; if (stray != 0) begin n_fail++; $display("FAIL basic_stray_underrun: got %0d want 0", stray); end
        stop_and_idle();
    endtask

    task automatic test_lj();
        logic [15:0] l [3];
        logic [15:0] r [3];
        int i;
        clear_mon();
        for (int k = 0; k < 3; k++) begin
            l[k] = (k == 0) ? 16'h8001 : 16'($urandom());
            r[k] = 16'($urandom());
            lj_l = l[k]; lj_r = r[k]; lj_valid = 1;
            tick(1);
        end
        lj_valid = 0;
        lj_enable = 1;
        for (i = 0; i < 500 && lq.size() < 3; i++) tick(1);
        n_chk++; if (lq.size() < 3) begin n_fail++; $display("FAIL lj_timeout: got %0d frames want 3", lq.size()); end
        if (lq.size() >= 3) begin
            for (int k = 0; k < 3; k++) begin
                n_chk++;
                if (lq[k] !== {l[k], r[k]}) begin n_fail++; $display("FAIL lj_frame%0d: got %h want %h", k, lq[k], {l[k], r[k]}); end
            end
        end
        lj_enable = 0;
        tick(200);
        n_chk++; if (lj_bclk !== 1'b0 || lj_lrclk !== 1'b1) begin n_fail++; $display("FAIL lj_idle: got bclk=%b lrclk=%b want 0/1", lj_bclk, lj_lrclk); end
    endtask

    task automatic test_underrun();
        bit ok;
        logic [47:0] e;
        clear_mon();
        enable = 1;
        wait_frames(2, ok);
        n_chk++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL ur_level0: got %0d want 0", fifo_level); end
        tick(10);
        push_rand();
        n_chk++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL ur_level1: got %0d want 1", fifo_level); end
        wait_frames(5, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL ur_timeout: got %0d frames want 5", frm_q.size()); end
        if (ok) begin
            e = exp_q.pop_front();
            for (int i = 0; i < 5; i++) begin
                n_chk++;
                if (ur_q[i] !== (i != 3)) begin n_fail++; $display("FAIL ur_flag%0d: got %b want %b", i, ur_q[i], i != 3); end
                n_chk++;
                if (frm_q[i] !== ((i == 3) ? {exp_i2s(e[47:24]), exp_i2s(e[23:0])} : 64'd0)) begin
                    n_fail++; $display("FAIL ur_frame%0d: got %h", i, frm_q[i]);
                end
            end
        end
        n_chk++; if (stray != 0) begin n_fail++; $display("FAIL ur_stray: got %0d want 0", stray); end
        stop_and_idle();
    endtask

    task automatic test_no_bypass();
        bit ok;
        logic [23:0] l, r;
        clear_mon();
        l = 24'($urandom()); r = 24'($urandom());
        s_data_l = l; s_data_r = r; s_valid = 1; enable = 1;
        tick(1);
        s_valid = 0;
        n_chk++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL nb_level: got %0d want 1", fifo_level); end
        wait_frames(2, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL nb_timeout: got %0d frames want 2", frm_q.size()); end
        if (ok) begin
            n_chk++; if (ur_q[0] !== 1'b1 || frm_q[0] !== 64'd0) begin n_fail++; $display("FAIL nb_first: got ur=%b data=%h want 1/0", ur_q[0], frm_q[0]); end
            n_chk++;
            if (ur_q[1] !== 1'b0 || frm_q[1] !== {exp_i2s(l), exp_i2s(r)}) begin
                n_fail++; $display("FAIL nb_second: got ur=%b data=%h want 0/%h", ur_q[1], frm_q[1], {exp_i2s(l), exp_i2s(r)});
            end
        end
        stop_and_idle();
    endtask

    task automatic test_full();
        bit ok;
        logic [47:0] e;
        clear_mon();
        for (int i = 0; i < 4; i++) push_rand();
        n_chk++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", s_ready); end
        n_chk++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL full_level: got %0d want 4", fifo_level); end
        s_data_l = 24'hDEAD01; s_data_r = 24'hBEEF02; s_valid = 1;
        tick(3);
        s_valid = 0;
        n_chk++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL full_level_hold: got %0d want 4", fifo_level); end
        enable = 1;
        wait_frames(5, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL full_timeout: got %0d frames want 5", frm_q.size()); end
        if (ok) begin
            for (int i = 0; i < 4; i++) begin
                e = exp_q.pop_front();
                n_chk++;
                if (frm_q[i] !== {exp_i2s(e[47:24]), exp_i2s(e[23:0])}) begin
                    n_fail++; $display("FAIL full_frame%0d: got %h want %h", i, frm_q[i], {exp_i2s(e[47:24]), exp_i2s(e[23:0])});
                end
            end
            n_chk++; if (ur_q[4] !== 1'b1 || frm_q[4] !== 64'd0) begin n_fail++; $display("FAIL full_fifth: got ur=%b data=%h want 1/0", ur_q[4], frm_q[4]); end
        end
        stop_and_idle();
    endtask

    task automatic test_disable();
        logic [47:0] e;
        clear_mon();
        push_rand();
        enable = 1;
        tick(40);
        enable = 0;
        tick(200);
        e = exp_q.pop_front();
        n_chk++; if (frm_q.size() != 1) begin n_fail++; $display("FAIL dis_count: got %0d frames want 1", frm_q.size()); end
        if (frm_q.size() >= 1) begin
            n_chk++;
            if (frm_q[0] !== {exp_i2s(e[47:24]), exp_i2s(e[23:0])}) begin
                n_fail++; $display("FAIL dis_frame: got %h want %h", frm_q[0], {exp_i2s(e[47:24]), exp_i2s(e[23:0])});
            end
        end
        n_chk++; if (bclk !== 1'b0 || lrclk !== 1'b1 || sdata !== 1'b0) begin n_fail++; $display("FAIL dis_idle: got %b%b%b want 010", bclk, lrclk, sdata); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [47:0] e;
        clear_mon();
        push_rand();
        push_rand();
        enable = 1;
        tick(84);
        #2 reset = 1;
        #1;
        n_chk++; if (bclk !== 1'b0 || lrclk !== 1'b1 || sdata !== 1'b0 || underrun !== 1'b0) begin
            n_fail++; $display("FAIL rst_async_out: got %b%b%b%b want 0100", bclk, lrclk, sdata, underrun);
        end
        n_chk++; if (fifo_level !== 3'd0 || s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_async_fifo: got level=%0d ready=%b want 0/1", fifo_level, s_ready); end
        enable = 0;
        tick(2);
        reset = 0;
        tick(2);
        clear_mon();
        push_rand();
        enable = 1;
        wait_frames(1, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL rst_restart_timeout: got %0d frames want 1", frm_q.size()); end
        if (ok) begin
            e = exp_q.pop_front();
            n_chk++;
            if (ur_q[0] !== 1'b0 || frm_q[0] !== {exp_i2s(e[47:24]), exp_i2s(e[23:0])}) begin
                n_fail++; $display("FAIL rst_restart_frame: got ur=%b data=%h want 0/%h", ur_q[0], frm_q[0], {exp_i2s(e[47:24]), exp_i2s(e[23:0])});
            end
        end
        stop_and_idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lj();
        test_underrun();
        test_no_bypass();
        test_full();
        test_disable();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
